// File: rtl/sdpram_fifo_pkg.sv
// rtl/sdpram_fifo_pkg.sv - shared sizing helpers for the SDP-RAM FIFO controller
package sdpram_fifo_pkg;

  function automatic int clog2(input int n);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

  // Output buffer must absorb every read in flight plus a steady-state pop.
  function automatic int obuf_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int level_w(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/sdpram_fifo_obuf.sv
// rtl/sdpram_fifo_obuf.sv - small register FIFO holding RAM read data for show-ahead output
module sdpram_fifo_obuf
  import sdpram_fifo_pkg::*;
#(
  parameter  int DEPTH  = 3,
  parameter  int DATA_W = 64,
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  cnt,
  output logic              vld
);

  localparam int IDX_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;

  // Entries shift toward slot 0 on pop, so a push lands just behind the surviving data.
  assign wr_idx    = IDX_W'(cnt - CNT_W'(pop));
  assign head_data = mem[0];
  assign vld       = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[wr_idx] <= push_data;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// rtl/sdpram_fifo_ctrl.sv - FIFO controller sequencing an external simple dual-port RAM
module sdpram_fifo_ctrl
  import sdpram_fifo_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 1,
  parameter int AFULL_TH  = 2**ADDR_W - 8,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_vld,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_rdy,
  output logic                rd_vld,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                rd_rdy,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_wraddress,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_rden,
  output logic [ADDR_W-1:0]   ram_rdaddress,
  input  logic [DATA_W-1:0]   ram_q,
  output logic [ADDR_W+1:0]   level,
  output logic                afull,
  output logic                aempty
);

  localparam int DEPTH      = 1 << ADDR_W;
  localparam int OBUF_DEPTH = obuf_depth(RD_LAT);
  localparam int OCW        = clog2(OBUF_DEPTH + 1);
  localparam int FCW        = clog2(RD_LAT + 1);

  typedef logic [ptr_w(ADDR_W)-1:0]   ptr_t;
  typedef logic [level_w(ADDR_W)-1:0] level_t;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("sdpram_fifo_ctrl: RD_LAT must be 1 or 2");
  end

  ptr_t              wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, ram_cnt, ram_cnt_nxt;
  logic [RD_LAT-1:0] tags, tags_nxt;
  logic [FCW-1:0]    inflight_cnt, inflight_nxt;
  logic [OCW-1:0]    obuf_cnt, obuf_cnt_nxt;
  logic              wr_fire, rd_issue, obuf_push, obuf_pop;
  level_t            level_nxt;

  // Registered pointers mean a slot written this cycle is only readable next cycle.
  assign ram_cnt      = wr_ptr - rd_ptr;
  assign inflight_cnt = FCW'($countones(tags));
  assign wr_fire      = wr_vld & wr_rdy & ~clr;
  assign rd_issue     = ~clr & (ram_cnt != '0) &
                        ((int'(inflight_cnt) + int'(obuf_cnt)) < OBUF_DEPTH);
  assign obuf_push    = tags[RD_LAT-1] & ~clr;
  assign obuf_pop     = rd_vld & rd_rdy & ~clr;

  assign ram_wren      = wr_fire;
  assign ram_wraddress = wr_ptr[ADDR_W-1:0];
  assign ram_data      = wr_data;
  assign ram_rden      = rd_issue;
  assign ram_rdaddress = rd_ptr[ADDR_W-1:0];

  always_comb begin
    wr_ptr_nxt   = wr_ptr + ptr_t'(wr_fire);
    rd_ptr_nxt   = rd_ptr + ptr_t'(rd_issue);
    tags_nxt     = RD_LAT'({tags, rd_issue});
    obuf_cnt_nxt = obuf_cnt + OCW'(obuf_push) - OCW'(obuf_pop);
    if (clr) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      tags_nxt     = '0;
      obuf_cnt_nxt = '0;
    end
    ram_cnt_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    inflight_nxt = FCW'($countones(tags_nxt));
    level_nxt    = level_t'(ram_cnt_nxt) + level_t'(inflight_nxt) + level_t'(obuf_cnt_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tags   <= '0;
      wr_rdy <= 1'b0;
      level  <= '0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      tags   <= tags_nxt;
      wr_rdy <= (ram_cnt_nxt != ptr_t'(DEPTH)) && !clr;
      level  <= level_nxt;
      afull  <= (ram_cnt_nxt >= ptr_t'(AFULL_TH));
      aempty <= (level_nxt <= level_t'(AEMPTY_TH));
    end
  end

  sdpram_fifo_obuf #(
    .DEPTH  (OBUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (obuf_push),
    .push_data (ram_q),
    .pop       (obuf_pop),
    .head_data (rd_data),
    .cnt       (obuf_cnt),
    .vld       (rd_vld)
  );

  assert property (@(posedge clk) disable iff (!rst_n)
    (rd_vld && !rd_rdy && !clr) |=> $stable(rd_data));
  assert property (@(posedge clk) disable iff (!rst_n)
    ram_cnt <= ptr_t'(DEPTH));

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// tb/tb_sdpram_fifo_ctrl.sv - randomized scoreboard bench for sdpram_fifo_ctrl at RD_LAT 1 and 2
module tb_sdpram_fifo_ctrl;

  localparam int AW     = 4;
  localparam int DW     = 64;
  localparam int DEPTH  = 1 << AW;
  localparam int AFULL  = DEPTH - 8;
  localparam int AEMPTY = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_vld = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_rdy = 1'b0;

  logic          wr_rdy [2];
  logic          rd_vld [2];
  logic [DW-1:0] rd_data [2];
  logic          ram_wren [2];
  logic [AW-1:0] ram_wraddress [2];
  logic [DW-1:0] ram_data [2];
  logic          ram_rden [2];
  logic [AW-1:0] ram_rdaddress [2];
  logic [AW+1:0] level [2];
  logic          afull [2];
  logic          aempty [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = g + 1;
    localparam int OD  = LAT + 2;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q1, q2, rq;
    logic [DW-1:0] mq [$];
    logic [DW-1:0] ob [$];
    logic [DW-1:0] fl_d [$];
    int            fl_rem [$];
    logic          m_wr_rdy = 1'b0;
    logic          m_afull  = 1'b0;
    logic          m_aempty = 1'b1;

    sdpram_fifo_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .RD_LAT (LAT)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr           (clr),
      .wr_vld        (wr_vld),
      .wr_data       (wr_data),
      .wr_rdy        (wr_rdy[g]),
      .rd_vld        (rd_vld[g]),
      .rd_data       (rd_data[g]),
      .rd_rdy        (rd_rdy),
      .ram_wren      (ram_wren[g]),
      .ram_wraddress (ram_wraddress[g]),
      .ram_data      (ram_data[g]),
      .ram_rden      (ram_rden[g]),
      .ram_rdaddress (ram_rdaddress[g]),
      .ram_q         (rq),
      .level         (level[g]),
      .afull         (afull[g]),
      .aempty        (aempty[g])
    );

    // External RAM: old data on read-during-write, optional output register.
    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_wraddress[g]] <= ram_data[g];
      if (ram_rden[g]) q1 <= mem[ram_rdaddress[g]];
      q2 <= q1;
    end
    assign rq = (LAT == 1) ? q1 : q2;

    // Reference: queues of entries in RAM, in flight (with cycles left) and buffered.
    always @(posedge clk or negedge rst_n) begin : model
      bit acc, iss;
      if (!rst_n || clr) begin
        mq.delete(); ob.delete(); fl_d.delete(); fl_rem.delete();
        m_wr_rdy = 1'b0;
        m_afull  = 1'b0;
        m_aempty = 1'b1;
      end else begin
        acc = wr_vld && m_wr_rdy;
        iss = (mq.size() > 0) && ((fl_d.size() + ob.size()) < OD);
        if (ob.size() > 0 && rd_rdy) void'(ob.pop_front());
        if (fl_rem.size() > 0 && fl_rem[0] == 1) begin
          ob.push_back(fl_d.pop_front());
          void'(fl_rem.pop_front());
        end
        foreach (fl_rem[i]) fl_rem[i] = fl_rem[i] - 1;
        if (iss) begin
          fl_d.push_back(mq.pop_front());
          fl_rem.push_back(LAT);
        end
        if (acc) mq.push_back(wr_data);
        m_wr_rdy = (mq.size() != DEPTH);
        m_afull  = (mq.size() >= AFULL);
        m_aempty = ((mq.size() + fl_d.size() + ob.size()) <= AEMPTY);
      end
    end

    always @(negedge clk) begin : compare
      int  lvl;
      bit  exp_rden;
      lvl      = mq.size() + fl_d.size() + ob.size();
      exp_rden = rst_n && !clr && (mq.size() > 0) && ((fl_d.size() + ob.size()) < OD);
      check($sformatf("lat%0d wr_rdy", LAT), wr_rdy[g], m_wr_rdy);
      check($sformatf("lat%0d rd_vld", LAT), rd_vld[g], ob.size() > 0);
      if (ob.size() > 0) check($sformatf("lat%0d rd_data", LAT), rd_data[g], ob[0]);
      check($sformatf("lat%0d level", LAT), level[g], lvl);
      check($sformatf("lat%0d afull", LAT), afull[g], m_afull);
      check($sformatf("lat%0d aempty", LAT), aempty[g], m_aempty);
      check($sformatf("lat%0d ram_wren", LAT), ram_wren[g], !clr && wr_vld && m_wr_rdy);
      check($sformatf("lat%0d ram_rden", LAT), ram_rden[g], exp_rden);
    end
  end

  initial begin
    int gaps [2];
    bit seen [2];

    repeat (3) tick();
    check("reset wr_rdy", wr_rdy[0], 0);
    check("reset aempty", aempty[1], 1);
    check("reset level", level[0], 0);
    rst_n = 1'b1;
    tick();
    check("wr_rdy after release lat1", wr_rdy[0], 1);
    check("wr_rdy after release lat2", wr_rdy[1], 1);

    // Single write of 0xA5 into an empty FIFO.
    rd_rdy = 1'b1; wr_vld = 1'b1; wr_data = 64'hA5;
    tick();
    wr_vld = 1'b0;
    check("single ram_rden c1 lat1", ram_rden[0], 1);
    check("single ram_rden c1 lat2", ram_rden[1], 1);
    check("single level c1", level[0], 1);
    tick(); tick();
    check("single rd_vld c3 lat1", rd_vld[0], 1);
    check("single rd_data c3 lat1", rd_data[0], 64'hA5);
    check("single rd_vld c3 lat2", rd_vld[1], 0);
    tick();
    check("single rd_vld c4 lat2", rd_vld[1], 1);
    check("single rd_data c4 lat2", rd_data[1], 64'hA5);
    check("single level c4 lat1", level[0], 0);
    tick();
    check("single level c5 lat2", level[1], 0);

    // Fill with the consumer stalled.
    rd_rdy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wr_vld = 1'b1; wr_data = 64'(i + 'h100);
      tick();
    end
    wr_vld = 1'b0;
    tick();
    check("fill level lat1", level[0], DEPTH + 3);
    check("fill level lat2", level[1], DEPTH + 4);
    check("fill wr_rdy lat1", wr_rdy[0], 0);
    check("fill wr_rdy lat2", wr_rdy[1], 0);
    check("fill afull lat1", afull[0], 1);
    check("fill head lat2", rd_data[1], 64'h100);

    rd_rdy = 1'b1;
    for (int i = 0; i < 100 && (level[0] != 0 || level[1] != 0); i++) tick();
    check("drain level lat1", level[0], 0);
    check("drain level lat2", level[1], 0);

    // Sustained streaming: one word per cycle after the initial latency.
    gaps[0] = 0; gaps[1] = 0;
    for (int i = 0; i < 1000; i++) begin
      wr_vld = 1'b1; wr_data = 64'(i);
      tick();
      for (int k = 0; k < 2; k++) if (i + 1 >= k + 3 && !rd_vld[k]) gaps[k]++;
    end
    wr_vld = 1'b0;
    check("stream gaps lat1", gaps[0], 0);
    check("stream gaps lat2", gaps[1], 0);
    repeat (10) tick();

    // Random traffic over many pointer wraps.
    for (int i = 0; i < 1200; i++) begin
      wr_vld  = ($urandom_range(0, 99) < 60);
      wr_data = {$urandom, $urandom};
      rd_rdy  = (i < 600) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 65);
      tick();
    end

    // Flush with the output buffer full and reads in flight.
    rd_rdy = 1'b0; wr_vld = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wr_data = 64'(i + 'h200);
      tick();
    end
    wr_vld = 1'b0; rd_rdy = 1'b1;
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr rd_vld lat1", rd_vld[0], 0);
    check("clr rd_vld lat2", rd_vld[1], 0);
    check("clr wr_rdy lat1", wr_rdy[0], 0);
    tick();
    check("clr wr_rdy back lat1", wr_rdy[0], 1);
    check("clr wr_rdy back lat2", wr_rdy[1], 1);
    wr_vld = 1'b1; wr_data = 64'h11;
    tick();
    wr_vld = 1'b0;
    seen[0] = 1'b0; seen[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_vld[k] && !seen[k]) begin
          check($sformatf("clr first word lat%0d", k + 1), rd_data[k], 64'h11);
          seen[k] = 1'b1;
        end
      end
      tick();
    end
    check("clr word seen lat1", seen[0], 1);
    check("clr word seen lat2", seen[1], 1);

    // Asynchronous reset in the middle of a stream.
    wr_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 64'(i + 'h300);
      tick();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async rst rd_vld", rd_vld[0], 0);
    check("async rst wr_rdy", wr_rdy[1], 0);
    check("async rst level", level[1], 0);
    check("async rst aempty", aempty[0], 1);
    check("async rst ram_wren", ram_wren[0], 0);
    wr_vld = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post rst wr_rdy lat1", wr_rdy[0], 1);
    check("post rst wr_rdy lat2", wr_rdy[1], 1);
    check("post rst level", level[0], 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
